// File: rtl/fifo_rr_wr_arbiter.sv
// Round-robin write-side arbiter: shares one FIFO write port among NUM_REQ producers,
// bounding each grant tenure to BURST_MAX accepted words and stalling on buf_full.
module fifo_rr_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  input  logic                         buf_full,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [NUM_REQ-1:0]           ack,
  output logic                         wr_en,
  output logic [DATA_W-1:0]            buf_in,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   cur_owner
);

  localparam int OWN_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_MAX - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t               state_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic                 busy_q;
  logic [OWN_W-1:0]     cur_owner_q;
  logic [OWN_W-1:0]     last_owner_q;
  logic [CNT_W-1:0]     burst_cnt_q;

  logic [DATA_W-1:0]    words [NUM_REQ];
  logic [OWN_W-1:0]     winner_idx;
  logic                 winner_found;
  logic                 owner_req;
  logic                 last_word;
  logic                 release_now;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      words[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Rotating search starting just after the previous owner; the previous owner is checked last.
  always_comb begin
    logic [OWN_W-1:0] cand;
    winner_found = 1'b0;
    winner_idx   = '0;
    cand         = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = OWN_W'((int'(last_owner_q) + k) % NUM_REQ);
      if (!winner_found && req[cand]) begin
        winner_found = 1'b1;
        winner_idx   = cand;
      end
    end
  end

  always_comb begin
    owner_req   = req[cur_owner_q];
    wr_en       = (state_q == ST_GRANT) && owner_req && !buf_full;
    buf_in      = wr_en ? words[cur_owner_q] : '0;
    ack         = wr_en ? (NUM_REQ'(1) << cur_owner_q) : '0;
    last_word   = (burst_cnt_q == LAST_CNT);
    release_now = (wr_en && last_word) || !owner_req;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      gnt_q        <= '0;
      busy_q       <= 1'b0;
      cur_owner_q  <= '0;
      last_owner_q <= OWN_W'(NUM_REQ - 1);
      burst_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (winner_found) begin
            state_q     <= ST_GRANT;
            cur_owner_q <= winner_idx;
            gnt_q       <= NUM_REQ'(1) << winner_idx;
            busy_q      <= 1'b1;
            burst_cnt_q <= '0;
          end
        end
        ST_GRANT: begin
          if (wr_en) begin
            burst_cnt_q <= burst_cnt_q + CNT_W'(1);
          end
          // cur_owner_q deliberately holds so it reports the last owner while idle.
          if (release_now) begin
            state_q      <= ST_IDLE;
            gnt_q        <= '0;
            busy_q       <= 1'b0;
            last_owner_q <= cur_owner_q;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign cur_owner = cur_owner_q;

endmodule

// File: doc/fifo_rr_wr_arbiter.md
Name: fifo_rr_wr_arbiter

Overview:
Round-robin write-side arbiter that shares one FIFO write port among NUM_REQ producers.
- Grants one producer at a time.
- Bounds each tenure to BURST_MAX accepted words.
- Drives the FIFO's wr_en/buf_in.
- Back-pressures all producers while the FIFO reports buf_full.
- Sits directly in front of the FIFO write interface; the FIFO read side is untouched.

Parameters:
NUM_REQ, 4, number of producers (2..8)
DATA_W, 8, word width; matches FIFO buf_in
BURST_MAX, 4, max words accepted per grant tenure (1..255)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-producer request; held high while producer has data
req_data  input  NUM_REQ*DATA_W  producer words; producer i at bits [i*DATA_W +: DATA_W]
buf_full  input  1  FIFO full flag
gnt  output  NUM_REQ  registered one-hot grant
ack  output  NUM_REQ  one-hot, combinational: word of producer i accepted this cycle
wr_en  output  1  FIFO write enable, combinational
buf_in  output  DATA_W  FIFO write data, combinational mux of owner's req_data
busy  output  1  high in GRANT state
cur_owner  output  clog2(NUM_REQ)  index of current/last owner

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, gnt=0, busy=0, cur_owner=0.
  - last_owner=NUM_REQ-1, so producer 0 has top priority after reset.
  - burst_cnt=0.
  - wr_en=0, ack=0, buf_in=0 (buf_in is forced 0 whenever wr_en=0).
- FSM, 2 states: IDLE, GRANT.
- IDLE:
  - If any req bit is high at the edge, pick the winner by searching last_owner+1, +2, ... mod NUM_REQ.
  - Next state GRANT; cur_owner<=winner, gnt<=onehot(winner), burst_cnt<=0.
  - No writes occur in IDLE.
- GRANT:
  - wr_en = req[cur_owner] & ~buf_full.
  - buf_in = req_data[cur_owner].
  - ack = wr_en ? onehot(cur_owner) : 0.
  - Each wr_en cycle increments burst_cnt (width clog2(BURST_MAX+1)).
- Release from GRANT to IDLE at the edge when either:
  - (a) wr_en=1 and burst_cnt==BURST_MAX-1, i.e. BURST_MAX-th word accepted; or
  - (b) req[cur_owner]=0.
  - On release: gnt<=0, last_owner<=cur_owner; cur_owner holds its value.
- Latency:
  - req sampled high at edge k gives gnt at edge k.
  - First wr_en is in the cycle after edge k.
  - Every release costs exactly one IDLE bubble cycle.
- Full handling:
  - buf_full=1 in GRANT gives wr_en=0 and ack=0.
  - burst_cnt frozen, grant held, no timeout.
  - Writes resume the first cycle buf_full=0.
- Producer contract:
  - Advance req_data on the edge where ack[i]=1.
  - May drop req only after an ack or before grant.
  - A word presented while not acked is not consumed.
- Simultaneous events:
  - A new request arriving during another's tenure waits for release.
  - A releasing owner that still requests is lowest priority at the next arbitration.
  - A single sole requester is re-granted after the bubble.
- Reset mid-burst: all state cleared immediately; any unacked word is not written.

Test Plan:
1. Hold rst=0 for 3 cycles with req=4'b1111 -> gnt=0, wr_en=0, ack=0, busy=0, cur_owner=0 throughout. Release rst -> gnt=4'b0001 after the first edge.
2. Only req[0], words 0x10..0x15 (6 words), buf_full=0 -> wr_en high 4 cycles writing 0x10-0x13, 1 IDLE cycle, regrant 0, writes 0x14,0x15, then req drops -> IDLE.
3. req=4'b0101 from reset, each with 8 words -> grant sequence 0,2,0,2. Each tenure is 4 writes, 1 bubble between tenures, 16 total writes in 19 cycles after first grant.
4. Producer 1 in GRANT after 2 writes, force buf_full=1 for 3 cycles -> wr_en=0, ack=0, gnt=4'b0010 held. Then 2 more writes and release, with a total of 4 words for the tenure.
5. Producer 3 drops req after 1 acked word while req[0] is high -> release at that edge, 1 bubble, then gnt=4'b0001 (wrap 3->0).
6. Assert rst=0 mid-burst (owner 2, burst_cnt=2) -> outputs zero asynchronously. After release with req=4'b0110, the first grant goes to producer 1.
